tm_l2_timing_model: RTL and testbench

- Shared last-level (L2) cache timing model for the multithreaded timing pipeline.
- Sits between the per-thread L1 miss stream and the DRAM timing model.
- For each L1 miss token it models tag lookup, hit latency, allocation and dirty-victim writeback, and emits the per-token DRAM request stream (token_valid, tid, request_valid, writeback_valid, addr) that the DRAM model consumes.
- It also merges the DRAM model's per-thread stall with its own hit-latency stall into one stall for the CPU.

---
 rtl/tm_l2_timing_model.sv | 230 +++++++++++++++++++++++
 tb/tb_tm_l2_timing_model.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/tm_l2_timing_model.sv
// rtl/tm_l2_timing_model.sv - shared direct-mapped L2 cache timing model feeding the DRAM timing model
module tm_l2_timing_model #(
    parameter int NTHREAD   = 64,
    parameter int ADDR_W    = 32,
    parameter int LINE_LOG2 = 5,
    parameter int SETS_LOG2 = 10,
    parameter int HIT_LAT_W = 4,
    localparam int TID_W    = $clog2(NTHREAD)
) (
    input  logic                 gclk,
    input  logic                 rst,
    input  logic [HIT_LAT_W-1:0] hit_latency,
    input  logic                 in_token_valid,
    input  logic [TID_W-1:0]     in_tid,
    input  logic                 in_req_valid,
    input  logic                 in_req_write,
    input  logic [ADDR_W-1:0]    in_req_addr,
    input  logic                 dram_stall,
    output logic                 out_token_valid,
    output logic [TID_W-1:0]     out_tid,
    output logic                 out_request_valid,
    output logic                 out_writeback_valid,
    output logic [ADDR_W-1:0]    out_request_addr,
    output logic [ADDR_W-1:0]    out_writeback_addr,
    output logic                 stall_out,
    output logic                 init_done,
    output logic                 proto_err,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt,
    output logic [31:0]          wb_cnt
);

    localparam int TAG_W    = ADDR_W - SETS_LOG2 - LINE_LOG2;
    localparam int LINE_W   = ADDR_W - LINE_LOG2;
    localparam int SETS     = 1 << SETS_LOG2;
    localparam int INIT_LEN = (SETS > NTHREAD) ? SETS : NTHREAD;
    localparam int IDX_W    = $clog2(INIT_LEN) + 1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } entry_t;

    // Tag store and per-thread remaining hit-latency tokens
    entry_t               tag_ram [SETS];
    logic [HIT_LAT_W-1:0] hit_ctr [NTHREAD];

    state_t               state;
    logic [IDX_W-1:0]     init_idx;

    // Stage-1 token registers (only the line address is kept)
    logic                 s1_valid;
    logic                 s1_req;
    logic                 s1_write;
    logic [TID_W-1:0]     s1_tid;
    logic [LINE_W-1:0]    s1_line;

    // Synchronous tag read and same-set bypass from the previous stage-1 write
    entry_t               tag_rd;
    entry_t               fwd_data;
    logic                 fwd_q;
    logic                 hit_stall_q;

    logic [SETS_LOG2-1:0] in_set;
    logic [SETS_LOG2-1:0] s1_set;
    logic [TAG_W-1:0]     s1_tag;
    entry_t               s1_entry;
    entry_t               s1_wdata;
    logic                 s1_active;
    logic                 s1_wr;
    logic                 s1_hit;
    logic                 s1_wb;
    logic [HIT_LAT_W-1:0] ctr_cur;
    logic [HIT_LAT_W-1:0] ctr_next;

    logic [SETS_LOG2-1:0] init_set;
    logic [TID_W-1:0]     init_tid;
    logic                 ram_we;
    logic [SETS_LOG2-1:0] ram_waddr;
    entry_t               ram_wdata;

    // Byte offset within the line never affects timing
    logic                 unused_offset_bits;
    assign unused_offset_bits = ^in_req_addr[LINE_LOG2-1:0];

    assign in_set   = in_req_addr[LINE_LOG2 +: SETS_LOG2];
    assign s1_set   = s1_line[SETS_LOG2-1:0];
    assign s1_tag   = s1_line[LINE_W-1:SETS_LOG2];
    assign init_set = init_idx[SETS_LOG2-1:0];
    assign init_tid = init_idx[TID_W-1:0];
    assign ctr_cur  = hit_ctr[s1_tid];

    // Stage-1 lookup: tag compare on bypassed state, victim check, next hit counter
    always_comb begin
        s1_entry       = fwd_q ? fwd_data : tag_rd;
        s1_active      = (state == ST_RUN) && s1_valid;
        s1_wr          = s1_active && s1_req;
        s1_hit         = s1_entry.valid && (s1_entry.tag == s1_tag);
        s1_wb          = !s1_hit && s1_entry.valid && s1_entry.dirty;
        s1_wdata.valid = 1'b1;
        s1_wdata.dirty = s1_hit ? (s1_entry.dirty | s1_write) : s1_write;
        s1_wdata.tag   = s1_tag;
        if (s1_req) begin
            ctr_next = s1_hit ? hit_latency : ctr_cur;
        end else if (ctr_cur != '0) begin
            ctr_next = ctr_cur - HIT_LAT_W'(1);
        end else begin
            ctr_next = '0;
        end
    end

    // Tag RAM write port: INIT clears sets, RUN allocates/updates from stage 1
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = s1_set;
        ram_wdata = s1_wdata;
        if (!rst) begin
            if (state == ST_INIT) begin
                ram_we    = ({1'b0, init_idx} < (IDX_W + 1)'(SETS));
                ram_waddr = init_set;
                ram_wdata = '0;
            end else begin
                ram_we = s1_wr;
            end
        end
    end

    // Synchronous tag RAM: read-before-write, bypass covers the same-set hazard
    always_ff @(posedge gclk) begin
        if (ram_we) begin
            tag_ram[ram_waddr] <= ram_wdata;
        end
        tag_rd <= tag_ram[in_set];
    end

    // Per-thread hit-latency counters, cleared by the INIT walk
    always_ff @(posedge gclk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                hit_ctr[init_tid] <= '0;
            end else if (s1_active) begin
                hit_ctr[s1_tid] <= ctr_next;
            end
        end
    end

    // Control FSM, stage-0 capture and registered stage-1 outputs
    always_ff @(posedge gclk) begin
        if (rst) begin
            state               <= ST_INIT;
            init_idx            <= '0;
            init_done           <= 1'b0;
            proto_err           <= 1'b0;
            s1_valid            <= 1'b0;
            s1_req              <= 1'b0;
            s1_write            <= 1'b0;
            s1_tid              <= '0;
            s1_line             <= '0;
            fwd_q               <= 1'b0;
            fwd_data            <= '0;
            hit_stall_q         <= 1'b0;
            out_token_valid     <= 1'b0;
            out_tid             <= '0;
            out_request_valid   <= 1'b0;
            out_writeback_valid <= 1'b0;
            out_request_addr    <= '0;
            out_writeback_addr  <= '0;
            hit_cnt             <= '0;
            miss_cnt            <= '0;
            wb_cnt              <= '0;
        end else begin
            out_token_valid     <= s1_active;
            out_tid             <= s1_tid;
            out_request_valid   <= s1_wr && !s1_hit;
            out_writeback_valid <= s1_wr && s1_wb;
            out_request_addr    <= (s1_wr && !s1_hit) ? {s1_line, {LINE_LOG2{1'b0}}} : '0;
            out_writeback_addr  <= (s1_wr && s1_wb) ?
                                   {s1_entry.tag, s1_set, {LINE_LOG2{1'b0}}} : '0;
            hit_stall_q         <= s1_active && (ctr_next != '0);
            if (s1_wr && s1_hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (s1_wr && !s1_hit) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
            if (s1_wr && s1_wb) begin
                wb_cnt <= wb_cnt + 32'd1;
            end
            if (s1_wr && (ctr_cur != '0)) begin
                proto_err <= 1'b1;
            end
            fwd_q    <= s1_wr && (s1_set == in_set);
            fwd_data <= s1_wdata;
            case (state)
                ST_INIT: begin
                    s1_valid <= 1'b0;
                    s1_req   <= 1'b0;
                    if (in_token_valid) begin
                        proto_err <= 1'b1;
                    end
                    init_idx <= init_idx + IDX_W'(1);
                    if (init_idx == IDX_W'(INIT_LEN - 1)) begin
                        state     <= ST_RUN;
                        init_done <= 1'b1;
                    end
                end
                ST_RUN: begin
                    s1_valid <= in_token_valid;
                    s1_req   <= in_token_valid && in_req_valid;
                    s1_write <= in_req_write;
                    s1_tid   <= in_tid;
                    s1_line  <= in_req_addr[ADDR_W-1:LINE_LOG2];
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    // DRAM stall is combinational for the thread currently on the output
    assign stall_out = out_token_valid & (hit_stall_q | dram_stall);

endmodule

// File: tb/tb_tm_l2_timing_model.sv
// tb/tb_tm_l2_timing_model.sv - directed self-checking bench for tm_l2_timing_model
module tb_tm_l2_timing_model;

    logic        gclk = 1'b0;
    logic        rst;
    logic [3:0]  hit_latency;
    logic        in_token_valid;
    logic [1:0]  in_tid;
    logic        in_req_valid;
    logic        in_req_write;
    logic [31:0] in_req_addr;
    logic        dram_stall;
    logic        out_token_valid;
    logic [1:0]  out_tid;
    logic        out_request_valid;
    logic        out_writeback_valid;
    logic [31:0] out_request_addr;
    logic [31:0] out_writeback_addr;
    logic        stall_out;
    logic        init_done;
    logic        proto_err;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
    logic [31:0] wb_cnt;

    int vecs = 0;
    int miscompares = 0;

    tm_l2_timing_model #(
        .NTHREAD   (4),
        .ADDR_W    (32),
        .LINE_LOG2 (5),
        .SETS_LOG2 (2),
        .HIT_LAT_W (4)
    ) dut (
        .gclk                (gclk),
        .rst                 (rst),
        .hit_latency         (hit_latency),
        .in_token_valid      (in_token_valid),
        .in_tid              (in_tid),
        .in_req_valid        (in_req_valid),
        .in_req_write        (in_req_write),
        .in_req_addr         (in_req_addr),
        .dram_stall          (dram_stall),
        .out_token_valid     (out_token_valid),
        .out_tid             (out_tid),
        .out_request_valid   (out_request_valid),
        .out_writeback_valid (out_writeback_valid),
        .out_request_addr    (out_request_addr),
        .out_writeback_addr  (out_writeback_addr),
        .stall_out           (stall_out),
        .init_done           (init_done),
        .proto_err           (proto_err),
        .hit_cnt             (hit_cnt),
        .miss_cnt            (miss_cnt),
        .wb_cnt              (wb_cnt)
    );

    always #5 gclk = ~gclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] tid, input logic rq,
                         input logic wr, input logic [31:0] a);
        in_token_valid = v;
        in_tid         = tid;
        in_req_valid   = rq;
        in_req_write   = wr;
        in_req_addr    = a;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 32'h0);
    endtask

    // one token through the pipeline, output observable on return
    task automatic access(input logic [1:0] tid, input logic wr, input logic [31:0] a);
        drive(1'b1, tid, 1'b1, wr, a);
        tick();
        idle();
        tick();
    endtask

    task automatic chk_tok(input string tag, input logic [1:0] tid, input logic rq,
                           input logic [31:0] ra, input logic wb, input logic [31:0] wa,
                           input logic st);
        chk({tag, ".tok"}, 32'(out_token_valid), 32'd1);
        chk({tag, ".tid"}, 32'(out_tid), 32'(tid));
        chk({tag, ".req"}, 32'(out_request_valid), 32'(rq));
        if (rq) chk({tag, ".req_addr"}, out_request_addr, ra);
        chk({tag, ".wb"}, 32'(out_writeback_valid), 32'(wb));
        if (wb) chk({tag, ".wb_addr"}, out_writeback_addr, wa);
        chk({tag, ".stall"}, 32'(stall_out), 32'(st));
    endtask

    initial begin
        rst         = 1'b1;
        hit_latency = 4'd3;
        dram_stall  = 1'b0;
        idle();
        tick();
        tick();
        chk("rst.tok", 32'(out_token_valid), 32'd0);
        chk("rst.req", 32'(out_request_valid), 32'd0);
        chk("rst.init_done", 32'(init_done), 32'd0);
        chk("rst.proto_err", 32'(proto_err), 32'd0);
        chk("rst.stall", 32'(stall_out), 32'd0);
        chk("rst.cnts", hit_cnt | miss_cnt | wb_cnt, 32'd0);

        // INIT: 4 cycles, token during INIT is a protocol error and is dropped
        rst = 1'b0;
        drive(1'b1, 2'd0, 1'b1, 1'b0, 32'h100);
        tick();
        chk("init.proto_err", 32'(proto_err), 32'd1);
        chk("init.tok1", 32'(out_token_valid), 32'd0);
        idle();
        tick();
        chk("init.drop", 32'(out_token_valid), 32'd0);
        chk("init.done2", 32'(init_done), 32'd0);
        tick();
        chk("init.done3", 32'(init_done), 32'd0);
        tick();
        chk("init.done4", 32'(init_done), 32'd1);

        // cold read miss
        access(2'd1, 1'b0, 32'h1234);
        chk_tok("cold", 2'd1, 1'b1, 32'h1220, 1'b0, 32'h0, 1'b0);
        chk("cold.miss_cnt", miss_cnt, 32'd1);

        // set 1 conflicts: evict clean, write-allocate, then evict dirty
        access(2'd2, 1'b0, 32'h12A0);
        chk_tok("conf_a", 2'd2, 1'b1, 32'h12A0, 1'b0, 32'h0, 1'b0);
        access(2'd2, 1'b1, 32'h1220);
        chk_tok("conf_b", 2'd2, 1'b1, 32'h1220, 1'b0, 32'h0, 1'b0);
        access(2'd2, 1'b0, 32'h12A0);
        chk_tok("conf_c", 2'd2, 1'b1, 32'h12A0, 1'b1, 32'h1220, 1'b0);
        chk("conf.wb_cnt", wb_cnt, 32'd1);
        chk("conf.miss_cnt", miss_cnt, 32'd4);

        // hit with latency 3, then three empty tokens: stall 1,1,1,0
        drive(1'b1, 2'd3, 1'b1, 1'b0, 32'h12A4);
        tick();
        drive(1'b1, 2'd3, 1'b0, 1'b0, 32'h0);
        tick();
        chk_tok("hit", 2'd3, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("hit.hit_cnt", hit_cnt, 32'd1);
        tick();
        chk("hit.stall_e1", 32'(stall_out), 32'd1);
        tick();
        chk("hit.stall_e2", 32'(stall_out), 32'd1);
        idle();
        tick();
        chk_tok("hit_e3", 2'd3, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("hit.miss_cnt", miss_cnt, 32'd4);

        // back-to-back same set: write miss A then read miss B sees dirty A
        drive(1'b1, 2'd0, 1'b1, 1'b1, 32'h0040);
        tick();
        drive(1'b1, 2'd0, 1'b1, 1'b0, 32'h00C0);
        tick();
        chk_tok("fwd_a", 2'd0, 1'b1, 32'h0040, 1'b0, 32'h0, 1'b0);
        idle();
        tick();
        chk_tok("fwd_b", 2'd0, 1'b1, 32'h00C0, 1'b1, 32'h0040, 1'b0);
        chk("fwd.wb_cnt", wb_cnt, 32'd2);
        chk("fwd.miss_cnt", miss_cnt, 32'd6);

        // DRAM stall merges combinationally
        dram_stall = 1'b1;
        drive(1'b1, 2'd0, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        tick();
        chk("dram.stall", 32'(stall_out), 32'd1);
        chk("dram.req", 32'(out_request_valid), 32'd0);
        dram_stall = 1'b0;
        #1;
        chk("dram.release", 32'(stall_out), 32'd0);

        // reset with a token in stage 1: dropped, INIT restarts
        drive(1'b1, 2'd1, 1'b1, 1'b0, 32'h1234);
        tick();
        rst = 1'b1;
        idle();
        tick();
        chk("mid.tok", 32'(out_token_valid), 32'd0);
        chk("mid.req", 32'(out_request_valid), 32'd0);
        chk("mid.init_done", 32'(init_done), 32'd0);
        chk("mid.proto_err", 32'(proto_err), 32'd0);
        chk("mid.cnts", hit_cnt | miss_cnt | wb_cnt, 32'd0);
        rst = 1'b0;
        tick();
        chk("mid.drop", 32'(out_token_valid), 32'd0);
        tick();
        tick();
        chk("mid.done3", 32'(init_done), 32'd0);
        tick();
        chk("mid.done4", 32'(init_done), 32'd1);

        // tags cleared by INIT; request during hit latency flags proto_err
        access(2'd1, 1'b0, 32'h12A0);
        chk_tok("re_miss", 2'd1, 1'b1, 32'h12A0, 1'b0, 32'h0, 1'b0);
        access(2'd1, 1'b0, 32'h12A0);
        chk_tok("re_hit", 2'd1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("re_hit.proto_err", 32'(proto_err), 32'd0);
        access(2'd1, 1'b0, 32'h12C0);
        chk("proto.req", 32'(out_request_valid), 32'd1);
        chk("proto.req_addr", out_request_addr, 32'h12C0);
        chk("proto.err", 32'(proto_err), 32'd1);
        chk("proto.miss_cnt", miss_cnt, 32'd2);
        chk("proto.hit_cnt", hit_cnt, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
